// File: rtl/bfp_shift_apply.sv
// Block-floating-point normalizer placed between FFT butterfly stages.
// Each beat carries DATA_WIDTH complex samples split into two halves; each
// half is left-shifted by its own clamped leading-bit count through a
// 2-stage pipeline. A per-half running minimum of the applied shifts is
// reported at frame end so the output stage can re-align exponents.
module bfp_shift_apply #(
  parameter int DATA_WIDTH = 16,
  parameter int BIT_W      = 13,
  parameter int CNT_W      = 5,
  parameter int MAX_SHIFT  = BIT_W - 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_valid,
  input  logic                    i_frame_start,
  input  logic                    i_frame_last,
  input  logic signed [BIT_W-1:0] i_data_re [0:DATA_WIDTH-1],
  input  logic signed [BIT_W-1:0] i_data_im [0:DATA_WIDTH-1],
  input  logic        [CNT_W-1:0] i_min_cnt_0,
  input  logic        [CNT_W-1:0] i_min_cnt_1,
  output logic                    o_valid,
  output logic signed [BIT_W-1:0] o_data_re [0:DATA_WIDTH-1],
  output logic signed [BIT_W-1:0] o_data_im [0:DATA_WIDTH-1],
  output logic        [CNT_W-1:0] o_shift_0,
  output logic        [CNT_W-1:0] o_shift_1,
  output logic                    o_frame_done,
  output logic        [CNT_W-1:0] o_frame_shift_0,
  output logic        [CNT_W-1:0] o_frame_shift_1
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [CNT_W-1:0] MAX_SHIFT_C = CNT_W'(MAX_SHIFT);

  // An all-zero half reports a large count; clamping keeps it from
  // shifting past the sample width.
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
    return (c > MAX_SHIFT_C) ? MAX_SHIFT_C : c;
  endfunction

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Stage 1 registers
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_start_q, s1_start_d;
  logic                    s1_last_q,  s1_last_d;
  logic        [CNT_W-1:0] s1_shift0_q, s1_shift0_d;
  logic        [CNT_W-1:0] s1_shift1_q, s1_shift1_d;
  logic signed [BIT_W-1:0] s1_re_q [0:DATA_WIDTH-1];
  logic signed [BIT_W-1:0] s1_re_d [0:DATA_WIDTH-1];
  logic signed [BIT_W-1:0] s1_im_q [0:DATA_WIDTH-1];
  logic signed [BIT_W-1:0] s1_im_d [0:DATA_WIDTH-1];

  // Stage 2 / output registers and frame tracker
  logic                    out_valid_q, out_valid_d;
  logic                    frame_done_q, frame_done_d;
  logic        [CNT_W-1:0] out_shift0_q, out_shift0_d;
  logic        [CNT_W-1:0] out_shift1_q, out_shift1_d;
  logic        [CNT_W-1:0] frame_shift0_q, frame_shift0_d;
  logic        [CNT_W-1:0] frame_shift1_q, frame_shift1_d;
  logic        [CNT_W-1:0] run_min0_q, run_min0_d;
  logic        [CNT_W-1:0] run_min1_q, run_min1_d;
  logic signed [BIT_W-1:0] out_re_q [0:DATA_WIDTH-1];
  logic signed [BIT_W-1:0] out_re_d [0:DATA_WIDTH-1];
  logic signed [BIT_W-1:0] out_im_q [0:DATA_WIDTH-1];
  logic signed [BIT_W-1:0] out_im_d [0:DATA_WIDTH-1];

  // Stage 1 next state: capture beat and clamp counts; hold data on bubbles.
  always_comb begin
    s1_valid_d  = i_valid;
    s1_start_d  = i_valid & i_frame_start;
    s1_last_d   = i_valid & i_frame_last;
    s1_shift0_d = s1_shift0_q;
    s1_shift1_d = s1_shift1_q;
    s1_re_d     = s1_re_q;
    s1_im_d     = s1_im_q;
    if (i_valid) begin
      s1_shift0_d = clamp_cnt(i_min_cnt_0);
      s1_shift1_d = clamp_cnt(i_min_cnt_1);
      for (int i = 0; i < DATA_WIDTH; i++) begin
        s1_re_d[i] = i_data_re[i];
        s1_im_d[i] = i_data_im[i];
      end
    end
  end

  // Stage 1 register; in-flight beats are dropped on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_start_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_shift0_q <= '0;
      s1_shift1_q <= '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        s1_re_q[i] <= '0;
        s1_im_q[i] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_start_q  <= s1_start_d;
      s1_last_q   <= s1_last_d;
      s1_shift0_q <= s1_shift0_d;
      s1_shift1_q <= s1_shift1_d;
      s1_re_q     <= s1_re_d;
      s1_im_q     <= s1_im_d;
    end
  end

  // Stage 2 next state: apply shifts and update the per-half frame minimum.
  // The tracker is never cleared by last, only reloaded by start, so beats
  // arriving without a start keep folding into the previous minimum.
  always_comb begin
    out_valid_d    = s1_valid_q;
    frame_done_d   = 1'b0;
    out_shift0_d   = out_shift0_q;
    out_shift1_d   = out_shift1_q;
    frame_shift0_d = frame_shift0_q;
    frame_shift1_d = frame_shift1_q;
    run_min0_d     = run_min0_q;
    run_min1_d     = run_min1_q;
    out_re_d       = out_re_q;
    out_im_d       = out_im_q;
    if (s1_valid_q) begin
      out_shift0_d = s1_shift0_q;
      out_shift1_d = s1_shift1_q;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (i < HALF) begin
          out_re_d[i] = s1_re_q[i] <<< s1_shift0_q;
          out_im_d[i] = s1_im_q[i] <<< s1_shift0_q;
        end else begin
          out_re_d[i] = s1_re_q[i] <<< s1_shift1_q;
          out_im_d[i] = s1_im_q[i] <<< s1_shift1_q;
        end
      end
      if (s1_start_q) begin
        run_min0_d = s1_shift0_q;
        run_min1_d = s1_shift1_q;
      end else begin
        run_min0_d = min_cnt(run_min0_q, s1_shift0_q);
        run_min1_d = min_cnt(run_min1_q, s1_shift1_q);
      end
      if (s1_last_q) begin
        frame_shift0_d = run_min0_d;
        frame_shift1_d = run_min1_d;
        frame_done_d   = 1'b1;
      end
    end
  end

  // Stage 2 register; tracker restarts from MAX_SHIFT after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      out_shift0_q   <= '0;
      out_shift1_q   <= '0;
      frame_shift0_q <= '0;
      frame_shift1_q <= '0;
      run_min0_q     <= MAX_SHIFT_C;
      run_min1_q     <= MAX_SHIFT_C;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        out_re_q[i] <= '0;
        out_im_q[i] <= '0;
      end
    end else begin
      out_valid_q    <= out_valid_d;
      frame_done_q   <= frame_done_d;
      out_shift0_q   <= out_shift0_d;
      out_shift1_q   <= out_shift1_d;
      frame_shift0_q <= frame_shift0_d;
      frame_shift1_q <= frame_shift1_d;
      run_min0_q     <= run_min0_d;
      run_min1_q     <= run_min1_d;
      out_re_q       <= out_re_d;
      out_im_q       <= out_im_d;
    end
  end

  assign o_valid         = out_valid_q;
  assign o_frame_done    = frame_done_q;
  assign o_shift_0       = out_shift0_q;
  assign o_shift_1       = out_shift1_q;
  assign o_frame_shift_0 = frame_shift0_q;
  assign o_frame_shift_1 = frame_shift1_q;
  assign o_data_re       = out_re_q;
  assign o_data_im       = out_im_q;

endmodule

// File: tb/tb_bfp_shift_apply.sv
// Bench for bfp_shift_apply: a table of hand-computed beats, randomized
// beats against a reference model, and a mid-flight reset sequence.
module tb_bfp_shift_apply;

  localparam int DW   = 16;
  localparam int BW   = 13;
  localparam int CW   = 5;
  localparam int MAXS = BW - 1;
  localparam int HALF = DW / 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_valid = 1'b0, i_frame_start = 1'b0, i_frame_last = 1'b0;
  logic signed [BW-1:0] i_data_re [0:DW-1];
  logic signed [BW-1:0] i_data_im [0:DW-1];
  logic [CW-1:0] i_min_cnt_0 = '0, i_min_cnt_1 = '0;
  logic o_valid, o_frame_done;
  logic signed [BW-1:0] o_data_re [0:DW-1];
  logic signed [BW-1:0] o_data_im [0:DW-1];
  logic [CW-1:0] o_shift_0, o_shift_1, o_frame_shift_0, o_frame_shift_1;

  always #5 clk = ~clk;

  bfp_shift_apply dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_frame_start(i_frame_start),
    .i_frame_last(i_frame_last), .i_data_re(i_data_re), .i_data_im(i_data_im),
    .i_min_cnt_0(i_min_cnt_0), .i_min_cnt_1(i_min_cnt_1), .o_valid(o_valid),
    .o_data_re(o_data_re), .o_data_im(o_data_im), .o_shift_0(o_shift_0),
    .o_shift_1(o_shift_1), .o_frame_done(o_frame_done),
    .o_frame_shift_0(o_frame_shift_0), .o_frame_shift_1(o_frame_shift_1)
  );

  typedef struct {
    bit v, s, l;
    logic [CW-1:0] c0, c1;
    logic signed [BW-1:0] re [0:DW-1];
    logic signed [BW-1:0] im [0:DW-1];
  } beat_t;

  typedef struct {
    bit ov, done;
    int sh0, sh1, fs0, fs1;
    logic signed [BW-1:0] re [0:DW-1];
    logic signed [BW-1:0] im [0:DW-1];
  } rec_t;

  typedef struct {
    int v, s, l, c0, c1, val0, val1;
    int ov, od, sh0, sh1, fs0, fs1, o0, o1;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  rec_t held, d1, d2, rst_rec;
  int run0, run1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  task automatic check_rec(input rec_t e);
    check("o_valid", 32'(o_valid), 32'(e.ov));
    check("o_frame_done", 32'(o_frame_done), 32'(e.done));
    check("o_shift_0", 32'(o_shift_0), e.sh0);
    check("o_shift_1", 32'(o_shift_1), e.sh1);
    check("o_frame_shift_0", 32'(o_frame_shift_0), e.fs0);
    check("o_frame_shift_1", 32'(o_frame_shift_1), e.fs1);
    for (int i = 0; i < DW; i++) begin
      check($sformatf("o_data_re[%0d]", i), 32'(o_data_re[i]), 32'(e.re[i]));
      check($sformatf("o_data_im[%0d]", i), 32'(o_data_im[i]), 32'(e.im[i]));
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // value * 2^s kept to BW bits, as a two's-complement sample would be
  function automatic logic signed [BW-1:0] scale(input logic signed [BW-1:0] v, input int s);
    int p;
    p = int'(v) * (1 << s);
    return BW'(p);
  endfunction

  task automatic model_reset();
    held = rst_rec;
    d1 = rst_rec;
    d2 = rst_rec;
    run0 = MAXS;
    run1 = MAXS;
  endtask

  // Drive one beat, advance one clock, check the beat that entered two clocks ago.
  task automatic cycle(input beat_t b);
    rec_t nr;
    int s0, s1;
    i_valid = b.v;
    i_frame_start = b.s;
    i_frame_last = b.l;
    i_min_cnt_0 = b.c0;
    i_min_cnt_1 = b.c1;
    i_data_re = b.re;
    i_data_im = b.im;
    nr = held;
    nr.ov = b.v;
    nr.done = 1'b0;
    if (b.v) begin
      s0 = imin(int'(b.c0), MAXS);
      s1 = imin(int'(b.c1), MAXS);
      nr.sh0 = s0;
      nr.sh1 = s1;
      for (int i = 0; i < DW; i++) begin
        nr.re[i] = scale(b.re[i], (i < HALF) ? s0 : s1);
        nr.im[i] = scale(b.im[i], (i < HALF) ? s0 : s1);
      end
      run0 = b.s ? s0 : imin(run0, s0);
      run1 = b.s ? s1 : imin(run1, s1);
      if (b.l) begin
        nr.fs0 = run0;
        nr.fs1 = run1;
        nr.done = 1'b1;
      end
    end
    held = nr;
    @(posedge clk);
    #1;
    d2 = d1;
    d1 = nr;
    check_rec(d2);
  endtask

  function automatic beat_t idle_beat();
    beat_t b;
    b.v = 0; b.s = 0; b.l = 0; b.c0 = '0; b.c1 = '0;
    for (int i = 0; i < DW; i++) begin
      b.re[i] = '0;
      b.im[i] = '0;
    end
    return b;
  endfunction

  function automatic beat_t row_beat(input vec_t r);
    beat_t b;
    b.v = (r.v != 0); b.s = (r.s != 0); b.l = (r.l != 0);
    b.c0 = CW'(r.c0); b.c1 = CW'(r.c1);
    for (int i = 0; i < DW; i++) begin
      b.re[i] = BW'((i < HALF) ? r.val0 : r.val1);
      b.im[i] = BW'((i < HALF) ? -r.val0 : -r.val1);
    end
    return b;
  endfunction

  // Data chosen so that value * 2^shift fits in BW bits, as upstream guarantees.
  function automatic beat_t rand_beat();
    beat_t b;
    int s, lim;
    b.v = ($urandom_range(0, 3) != 0);
    b.s = ($urandom_range(0, 9) == 0);
    b.l = ($urandom_range(0, 9) == 0);
    b.c0 = CW'($urandom_range(0, 31));
    b.c1 = CW'($urandom_range(0, 31));
    for (int i = 0; i < DW; i++) begin
      s = imin(int'((i < HALF) ? b.c0 : b.c1), MAXS);
      lim = 1 << (MAXS - s);
      b.re[i] = BW'(int'($urandom_range(0, 2 * lim - 1)) - lim);
      b.im[i] = BW'(int'($urandom_range(0, 2 * lim - 1)) - lim);
    end
    return b;
  endfunction

  task automatic check_row(input int k, input vec_t r);
    check($sformatf("tbl%0d o_valid", k), 32'(o_valid), r.ov);
    check($sformatf("tbl%0d o_frame_done", k), 32'(o_frame_done), r.od);
    check($sformatf("tbl%0d o_shift_0", k), 32'(o_shift_0), r.sh0);
    check($sformatf("tbl%0d o_shift_1", k), 32'(o_shift_1), r.sh1);
    check($sformatf("tbl%0d o_frame_shift_0", k), 32'(o_frame_shift_0), r.fs0);
    check($sformatf("tbl%0d o_frame_shift_1", k), 32'(o_frame_shift_1), r.fs1);
    check($sformatf("tbl%0d re0", k), 32'(o_data_re[0]), r.o0);
    check($sformatf("tbl%0d im0", k), 32'(o_data_im[0]), -r.o0);
    check($sformatf("tbl%0d re%0d", k, DW - 1), 32'(o_data_re[DW-1]), r.o1);
    check($sformatf("tbl%0d im%0d", k, DW - 1), 32'(o_data_im[DW-1]), -r.o1);
  endtask

  vec_t tbl [0:10];

  initial begin
    beat_t b;
    rst_rec.ov = 0; rst_rec.done = 0;
    rst_rec.sh0 = 0; rst_rec.sh1 = 0; rst_rec.fs0 = 0; rst_rec.fs1 = 0;
    for (int i = 0; i < DW; i++) begin
      rst_rec.re[i] = '0;
      rst_rec.im[i] = '0;
      i_data_re[i] = '0;
      i_data_im[i] = '0;
    end
    model_reset();

    //          v s l c0 c1 val0 val1 | ov od sh0 sh1 fs0 fs1   o0     o1
    tbl[0]  = '{1,1,1, 5, 9, 100,  -7,   1, 1,  5,  9,  5,  9, 3200, -3584};
    tbl[1]  = '{1,1,0, 6, 2,   1,   3,   1, 0,  6,  2,  5,  9,   64,    12};
    tbl[2]  = '{1,0,0, 3, 2,   1,   3,   1, 0,  3,  2,  5,  9,    8,    12};
    tbl[3]  = '{0,1,1, 0, 0,   0,   0,   0, 0,  3,  2,  5,  9,    8,    12};
    tbl[4]  = '{1,0,0, 8, 2,   1,   3,   1, 0,  8,  2,  5,  9,  256,    12};
    tbl[5]  = '{1,0,1, 4, 2,   1,   3,   1, 1,  4,  2,  3,  2,   16,    12};
    tbl[6]  = '{1,1,1,31, 0,   0,  -5,   1, 1, 12,  0, 12,  0,    0,    -5};
    tbl[7]  = '{1,1,0, 2, 7,   1,   1,   1, 0,  2,  7, 12,  0,    4,   128};
    tbl[8]  = '{1,0,0, 1, 8,   1,   1,   1, 0,  1,  8, 12,  0,    2,   256};
    tbl[9]  = '{1,1,0, 4, 5,   1,   1,   1, 0,  4,  5, 12,  0,   16,    32};
    tbl[10] = '{1,0,1, 6, 6,   1,   1,   1, 1,  6,  6,  4,  5,   64,    64};

    repeat (2) @(posedge clk);
    #1;
    check_rec(rst_rec);
    rstn = 1'b1;

    for (int k = 0; k <= 10; k++) begin
      cycle(row_beat(tbl[k]));
      if (k > 0) check_row(k - 1, tbl[k-1]);
    end
    cycle(idle_beat());
    check_row(10, tbl[10]);
    cycle(idle_beat());

    for (int n = 0; n < 500; n++) cycle(rand_beat());

    // Reset with a beat in stage 1 and another on the inputs.
    b = row_beat(tbl[0]);
    cycle(b);
    i_valid = 1'b1;
    i_frame_start = 1'b1;
    i_frame_last = 1'b1;
    #1 rstn = 1'b0;
    #1;
    model_reset();
    check_rec(rst_rec);
    @(posedge clk);
    #1;
    check_rec(rst_rec);
    rstn = 1'b1;

    // Last without any start folds into the MAX_SHIFT reset value.
    b = idle_beat();
    b.v = 1; b.l = 1; b.c0 = 5'd7; b.c1 = 5'd20;
    for (int i = 0; i < DW; i++) begin
      b.re[i] = 13'sd2;
      b.im[i] = -13'sd1;
    end
    cycle(b);
    check("post-reset latency o_valid", 32'(o_valid), 32'd0);
    cycle(idle_beat());
    check("no-start o_frame_done", 32'(o_frame_done), 32'd1);
    check("no-start o_frame_shift_0", 32'(o_frame_shift_0), 32'd7);
    check("no-start o_frame_shift_1", 32'(o_frame_shift_1), 32'd12);
    check("no-start re0", 32'(o_data_re[0]), 32'd256);
    cycle(idle_beat());

    for (int n = 0; n < 200; n++) cycle(rand_beat());
    cycle(idle_beat());
    cycle(idle_beat());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
